// File: rtl/wb_pkg.sv
// Wishbone B3 shared definitions.
// Used by the slave RAM and the wb_master_scr side.
package wb_pkg;

    localparam int WB_AW   = 32;
    localparam int WB_DW   = 32;
    localparam int WB_SELW = 4;

    typedef enum logic [1:0] {
        WBS_IDLE,
        WBS_WAIT,
        WBS_ACK
    } type_wbs_state_e;

endpackage

// File: rtl/wb_slave_ram_array.sv
// Single-port word RAM with byte write enables.
// Read data is registered; contents are never reset.
module wb_slave_ram_array
    import wb_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic               clk,
    input  logic [WB_SELW-1:0] be,
    input  logic [AW-1:0]      addr,
    input  logic [WB_DW-1:0]   wdata,
    output logic [WB_DW-1:0]   rdata
);

    logic [WB_DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        for (int i = 0; i < WB_SELW; i++) begin
            if (be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wb_slave_ram.sv
// Wishbone classic slave RAM with programmable wait states.
// Define WB_SLAVE_RAM_ERR_EN to add wbs_err_o for out-of-range accesses.
module wb_slave_ram
    import wb_pkg::*;
#(
    parameter int              ADDR_WIDTH  = 12,
    parameter logic [WB_AW-1:0] BASE_ADDR  = 32'h0000_0000,
    parameter int              WAIT_STATES = 0
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic [WB_AW-1:0]   wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    output logic [WB_DW-1:0]   wbs_dat_o,
    input  logic               wbs_we_i,
    input  logic [WB_SELW-1:0] wbs_sel_i,
    input  logic               wbs_stb_i,
    input  logic               wbs_cyc_i,
`ifdef WB_SLAVE_RAM_ERR_EN
    output logic               wbs_err_o,
`endif
    output logic               wbs_ack_o
);

    localparam bit         NO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_INIT = 4'(NO_WAIT ? 0 : WAIT_STATES - 1);

    type_wbs_state_e state, state_nxt;
    logic [3:0]      cnt, cnt_nxt;

    logic                  req;
    logic                  in_range;
    logic                  in_ack;
    logic                  xfer_ok;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [WB_SELW-1:0]    be;
    logic [WB_DW-1:0]      rd_data;

    assign req      = wbs_cyc_i & wbs_stb_i;
    assign in_range = wbs_adr_i[WB_AW-1:ADDR_WIDTH+2]
                   == BASE_ADDR[WB_AW-1:ADDR_WIDTH+2];
    assign word_idx = wbs_adr_i[ADDR_WIDTH+1:2];
    assign in_ack   = (state == WBS_ACK);
    assign xfer_ok  = in_ack & in_range;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state <= WBS_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // A dropped request while waiting aborts silently.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            WBS_IDLE: begin
                if (req) begin
                    if (NO_WAIT) begin
                        state_nxt = WBS_ACK;
                    end else begin
                        state_nxt = WBS_WAIT;
                        cnt_nxt   = WS_INIT;
                    end
                end
            end
            WBS_WAIT: begin
                if (!req) begin
                    state_nxt = WBS_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == 4'd0) begin
                    state_nxt = WBS_ACK;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WBS_ACK: begin
                state_nxt = WBS_IDLE;
            end
            default: begin
                state_nxt = WBS_IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    assign be = (xfer_ok & wbs_we_i) ? wbs_sel_i : '0;

    wb_slave_ram_array #(
        .AW(ADDR_WIDTH)
    ) u_array (
        .clk  (wb_clk_i),
        .be   (be),
        .addr (word_idx),
        .wdata(wbs_dat_i),
        .rdata(rd_data)
    );

    assign wbs_dat_o = (xfer_ok & ~wbs_we_i) ? rd_data : '0;

`ifdef WB_SLAVE_RAM_ERR_EN
    assign wbs_ack_o = xfer_ok;
    assign wbs_err_o = in_ack & ~in_range;
`else
    assign wbs_ack_o = in_ack;
`endif

endmodule

// File: tb/tb_wb_slave_ram.sv
// Directed bench for wb_slave_ram at zero and three wait states.
// Read data is checked against a queue filled at issue time.
module tb_wb_slave_ram;

`ifdef WB_SLAVE_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] adr = '0;
    logic [31:0] dat = '0;
    logic        we = 1'b0;
    logic [3:0]  sel = '0;
    logic        cyc = 1'b0;
    logic        stb0 = 1'b0;
    logic        stb3 = 1'b0;
    logic [31:0] dat0, dat3;
    logic        ack0, ack3;
    logic        err0, err3;

    int n_chk = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    wb_slave_ram #(.WAIT_STATES(0)) u_fast (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_dat_o (dat0),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_stb_i (stb0),
        .wbs_cyc_i (cyc),
`ifdef WB_SLAVE_RAM_ERR_EN
        .wbs_err_o (err0),
`endif
        .wbs_ack_o (ack0)
    );

    wb_slave_ram #(.WAIT_STATES(3)) u_slow (
        .wb_clk_i  (clk),
        .wb_rst_n_i(rst_n),
        .wbs_adr_i (adr),
        .wbs_dat_i (dat),
        .wbs_dat_o (dat3),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_stb_i (stb3),
        .wbs_cyc_i (cyc),
`ifdef WB_SLAVE_RAM_ERR_EN
        .wbs_err_o (err3),
`endif
        .wbs_ack_o (ack3)
    );

`ifndef WB_SLAVE_RAM_ERR_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic xfer(input bit slow, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] rd_exp, input bit oor);
        int          n;
        bit          got;
        logic        h_ack, h_err;
        logic [31:0] rd;
        bit          exp_err;
        exp_err = oor & ERR_EN;
        if (!w) exp_q.push_back(rd_exp);
        @(negedge clk);
        adr = a; dat = d; we = w; sel = s; cyc = 1'b1;
        if (slow) stb3 = 1'b1;
        else stb0 = 1'b1;
        n = 0; got = 1'b0; h_ack = 1'b0; h_err = 1'b0; rd = '0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            h_ack = slow ? ack3 : ack0;
            h_err = slow ? err3 : err0;
            rd    = slow ? dat3 : dat0;
            got   = h_ack | h_err;
        end
        check("handshake", 32'(got), 32'd1);
        check("latency", 32'(n), slow ? 32'd4 : 32'd1);
        check("ack", 32'(h_ack), 32'(!exp_err));
        check("err", 32'(h_err), 32'(exp_err));
        if (!w) check("rdata", rd, exp_q.pop_front());
        @(posedge clk); #1;
        check("ack_width", 32'(slow ? ack3 : ack0), 32'd0);
        check("dat_idle", slow ? dat3 : dat0, 32'd0);
        cyc = 1'b0; stb0 = 1'b0; stb3 = 1'b0;
    endtask

    initial begin
        int  n;
        bit  seen;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack0", 32'(ack0), 32'd0);
        check("rst_dat0", dat0, 32'd0);
        check("rst_ack3", 32'(ack3), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, '0, 0);
        xfer(0, 0, 32'h10, 32'h0, 4'hF, 32'hDEADBEEF, 0);

        xfer(0, 1, 32'h20, 32'h11223344, 4'hF, '0, 0);
        xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, '0, 0);
        xfer(0, 0, 32'h22, 32'h0, 4'h1, 32'h11BB33DD, 0);
        xfer(0, 1, 32'h20, 32'hFFFFFFFF, 4'b0000, '0, 0);
        xfer(0, 0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 0);

        // stb without cyc is not a request
        @(negedge clk);
        adr = 32'h10; we = 1'b0; stb0 = 1'b1; cyc = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | ack0;
        end
        check("stb_no_cyc", 32'(seen), 32'd0);
        stb0 = 1'b0;

        xfer(1, 1, 32'h30, 32'h12345678, 4'hF, '0, 0);
        xfer(1, 0, 32'h30, 32'h0, 4'hF, 32'h12345678, 0);

        // abort a slow write by dropping cyc
        @(negedge clk);
        adr = 32'h30; dat = 32'h55; we = 1'b1; sel = 4'hF;
        cyc = 1'b1; stb3 = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            seen = seen | ack3;
        end
        cyc = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack3;
        end
        check("abort_no_ack", 32'(seen), 32'd0);
        stb3 = 1'b0;
        xfer(1, 0, 32'h30, 32'h0, 4'hF, 32'h12345678, 0);

        // reset during the ack cycle must cancel the write
        xfer(1, 1, 32'h40, 32'hA5A5A5A5, 4'hF, '0, 0);
        @(negedge clk);
        adr = 32'h40; dat = 32'h0F0F0F0F; we = 1'b1; sel = 4'hF;
        cyc = 1'b1; stb3 = 1'b1;
        n = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk); #1;
            n++;
            seen = ack3;
        end
        check("pre_rst_ack", 32'(seen), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_async_ack", 32'(ack3), 32'd0);
        cyc = 1'b0; stb3 = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 0, 32'h40, 32'h0, 4'hF, 32'hA5A5A5A5, 0);

        // one word past the top of the RAM
        xfer(0, 1, 32'h0, 32'hCAFEF00D, 4'hF, '0, 0);
        xfer(0, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, '0, 1);
        xfer(0, 0, 32'h4000, 32'h0, 4'hF, 32'h0, 1);
        xfer(0, 0, 32'h0, 32'h0, 4'hF, 32'hCAFEF00D, 0);
        xfer(1, 0, 32'h4000, 32'h0, 4'hF, 32'h0, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
